// File: rtl/branch_resolve_unit_pkg.sv
// Shared encodings for the branch resolve unit: op kinds, branch funct3
// codes, FSM state type and the default datapath width.
package branch_resolve_unit_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [1:0] {
        OP_NONE   = 2'b00,
        OP_BRANCH = 2'b01,
        OP_JAL    = 2'b10,
        OP_JALR   = 2'b11
    } op_kind_e;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'b00,
        ST_FULL   = 2'b01,
        ST_SQUASH = 2'b10
    } state_e;

endpackage

// File: rtl/branch_resolve_unit_cond_eval.sv
// Pure combinational evaluation of a conditional-branch funct3 against two
// operands. Reserved encodings (010/011) report illegal and never take.
module branch_cond_eval
    import branch_resolve_unit_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs_1_i,
    input  logic [XLEN-1:0] rs_2_i,
    output logic            taken_o,
    output logic            illegal_o
);

    // Select the comparison named by funct3
    always_comb begin
        taken_o   = 1'b0;
        illegal_o = 1'b0;
        case (funct3_i)
            F3_BEQ:  taken_o = (rs_1_i == rs_2_i);
            F3_BNE:  taken_o = (rs_1_i != rs_2_i);
            F3_BLT:  taken_o = ($signed(rs_1_i) <  $signed(rs_2_i));
            F3_BGE:  taken_o = ($signed(rs_1_i) >= $signed(rs_2_i));
            F3_BLTU: taken_o = (rs_1_i <  rs_2_i);
            F3_BGEU: taken_o = (rs_1_i >= rs_2_i);
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: resolves branch/jump direction and target, compares
// against the front-end prediction and holds one registered result behind a
// valid/ready handshake. A mispredicted result raises a one-cycle flush when
// it is consumed, followed by one SQUASH cycle that refuses new requests.
//
//  state   | meaning
//  EMPTY   | no result held; ready for a request
//  FULL    | result held and presented downstream
//  SQUASH  | one dead cycle after a flush; requests refused
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      op_kind,
    input  logic [2:0]      br_funct3,
    input  logic [XLEN-1:0] rs_1,
    input  logic [XLEN-1:0] rs_2,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic            pred_taken,
    input  logic [XLEN-1:0] pred_target,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            taken,
    output logic [XLEN-1:0] target,
    output logic [XLEN-1:0] link_addr,
    output logic            mispredict,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush,
    output logic            illegal,
    output logic            misalign
);

    state_e          state_q, state_d;
    logic            cond_taken, cond_illegal;
    logic            taken_d, illegal_d, mispredict_d, misalign_d;
    logic [XLEN-1:0] target_d, link_d, redirect_d;
    logic            taken_q, illegal_q, mispredict_q, misalign_q;
    logic [XLEN-1:0] target_q, link_q, redirect_q;
    logic            accept;

    branch_cond_eval #(.XLEN(XLEN)) u_cond (
        .funct3_i  (br_funct3),
        .rs_1_i    (rs_1),
        .rs_2_i    (rs_2),
        .taken_o   (cond_taken),
        .illegal_o (cond_illegal)
    );

    // Resolve direction, target and prediction check for the offered request
    always_comb begin
        taken_d   = 1'b0;
        illegal_d = 1'b0;
        target_d  = pc + imm;
        link_d    = pc + XLEN'(4);
        case (op_kind_e'(op_kind))
            OP_BRANCH: begin
                taken_d   = cond_taken;
                illegal_d = cond_illegal;
            end
            OP_JAL:  taken_d = 1'b1;
            OP_JALR: begin
                taken_d  = 1'b1;
                target_d = (rs_1 + imm) & ~XLEN'(1);
            end
            default: taken_d = 1'b0;
        endcase
        redirect_d   = taken_d ? target_d : link_d;
        misalign_d   = taken_d & target_d[1];
        mispredict_d = (op_kind != OP_NONE) &&
                       ((taken_d != pred_taken) || (taken_d && (target_d != pred_target)));
    end

    assign accept = in_valid && in_ready;

    // Capture the resolved result on an accepted request
    always_ff @(posedge clk) begin
        if (rst) begin
            taken_q      <= 1'b0;
            illegal_q    <= 1'b0;
            mispredict_q <= 1'b0;
            misalign_q   <= 1'b0;
            target_q     <= '0;
            link_q       <= '0;
            redirect_q   <= '0;
        end else if (accept) begin
            taken_q      <= taken_d;
            illegal_q    <= illegal_d;
            mispredict_q <= mispredict_d;
            misalign_q   <= misalign_d;
            target_q     <= target_d;
            link_q       <= link_d;
            redirect_q   <= redirect_d;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_EMPTY;
        else     state_q <= state_d;
    end

    // Next state and handshake outputs; reset masks in_ready and flush so a
    // held result is dropped silently
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        flush     = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                in_ready = !rst;
                if (in_valid) state_d = ST_FULL;
            end
            ST_FULL: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (mispredict_q) begin
                        flush   = !rst;
                        state_d = ST_SQUASH;
                    end else begin
                        in_ready = !rst;
                        state_d  = in_valid ? ST_FULL : ST_EMPTY;
                    end
                end
            end
            ST_SQUASH: state_d = ST_EMPTY;
            default:   state_d = ST_EMPTY;
        endcase
    end

    assign taken       = taken_q;
    assign target      = target_q;
    assign link_addr   = link_q;
    assign mispredict  = mispredict_q;
    assign redirect_pc = redirect_q;
    assign illegal     = illegal_q;
    assign misalign    = misalign_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: expected results are computed by
// a reference model when a request is accepted and compared on consumption.
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, in_ready;
    logic [1:0]  op_kind = '0;
    logic [2:0]  br_funct3 = '0;
    logic [31:0] rs_1 = '0, rs_2 = '0, pc = '0, imm = '0, pred_target = '0;
    logic        pred_taken = 1'b0;
    logic        out_valid, out_ready = 1'b0;
    logic        taken, mispredict, flush, illegal, misalign;
    logic [31:0] target, link_addr, redirect_pc;

    always #5 clk = ~clk;

    branch_resolve_unit #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op_kind(op_kind), .br_funct3(br_funct3), .rs_1(rs_1), .rs_2(rs_2),
        .pc(pc), .imm(imm), .pred_taken(pred_taken), .pred_target(pred_target),
        .out_valid(out_valid), .out_ready(out_ready), .taken(taken),
        .target(target), .link_addr(link_addr), .mispredict(mispredict),
        .redirect_pc(redirect_pc), .flush(flush), .illegal(illegal),
        .misalign(misalign)
    );

    typedef struct packed {
        logic [1:0]  op;
        logic [2:0]  f3;
        logic [31:0] rs1, rs2, pc, imm;
        logic        pt;
        logic [31:0] ptgt;
    } req_t;

    typedef struct packed {
        logic        taken;
        logic [31:0] target, link, redirect;
        logic        mis, ill, misal;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad = 0;
    logic acc, cons, flush_s, ir_s, ov_s;
    exp_t obs, e;
    req_t idle_r = '0;

    function automatic req_t mk(logic [1:0] op, logic [2:0] f3, logic [31:0] a, logic [31:0] b,
                                logic [31:0] p, logic [31:0] i, logic pt, logic [31:0] ptgt);
        req_t r;
        r.op = op; r.f3 = f3; r.rs1 = a; r.rs2 = b; r.pc = p; r.imm = i; r.pt = pt; r.ptgt = ptgt;
        return r;
    endfunction

    function automatic exp_t model(req_t r);
        exp_t x;
        x = '0;
        x.link   = r.pc + 32'd4;
        x.target = r.pc + r.imm;
        case (r.op)
            2'b01: case (r.f3)
                3'b000: x.taken = (r.rs1 == r.rs2);
                3'b001: x.taken = (r.rs1 != r.rs2);
                3'b100: x.taken = ($signed(r.rs1) <  $signed(r.rs2));
                3'b101: x.taken = ($signed(r.rs1) >= $signed(r.rs2));
                3'b110: x.taken = (r.rs1 <  r.rs2);
                3'b111: x.taken = (r.rs1 >= r.rs2);
                default: x.ill = 1'b1;
            endcase
            2'b10: x.taken = 1'b1;
            2'b11: begin x.taken = 1'b1; x.target = (r.rs1 + r.imm) & 32'hFFFF_FFFE; end
            default: x.taken = 1'b0;
        endcase
        x.redirect = x.taken ? x.target : x.link;
        x.misal    = x.taken & x.target[1];
        x.mis      = (r.op != 2'b00) && ((x.taken != r.pt) || (x.taken && x.target != r.ptgt));
        return x;
    endfunction

    // One clock: drive inputs just after the edge, sample shortly after
    task automatic cycle(input logic r_i, input logic iv, input logic ordy, input req_t r);
        @(posedge clk); #1;
        rst = r_i; in_valid = iv; out_ready = ordy;
        op_kind = r.op; br_funct3 = r.f3; rs_1 = r.rs1; rs_2 = r.rs2;
        pc = r.pc; imm = r.imm; pred_taken = r.pt; pred_target = r.ptgt;
        #1;
        acc = in_valid && in_ready;
        cons = out_valid && out_ready;
        flush_s = flush; ir_s = in_ready; ov_s = out_valid;
        obs = {taken, target, link_addr, redirect_pc, mispredict, illegal, misalign};
        if (acc) sbq.push_back(model(r));
    endtask

    task automatic test_reset();
        cycle(1, 0, 0, idle_r);
        cycle(1, 0, 0, idle_r);
        total++; if (ir_s !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%0b want=0", ir_s); end
        total++; if (ov_s !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", ov_s); end
        total++; if (flush_s !== 1'b0) begin bad++; $display("FAIL reset_flush got=%0b want=0", flush_s); end
        total++; if (obs !== exp_t'(0)) begin bad++; $display("FAIL reset_outputs got=%h want=0", obs); end
        cycle(0, 0, 0, idle_r);
        total++; if (ir_s !== 1'b1) begin bad++; $display("FAIL reset_release_ready got=%0b want=1", ir_s); end
    endtask

    task automatic test_blt_mispredict();
        cycle(0, 1, 0, mk(2'b01, 3'b100, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b0, 32'h0));
        total++; if (acc !== 1'b1) begin bad++; $display("FAIL blt_accept got=%0b want=1", acc); end
        cycle(0, 0, 0, idle_r);
        total++; if ({ov_s, ir_s, flush_s} !== 3'b100) begin bad++; $display("FAIL blt_hold got=%b want=100", {ov_s, ir_s, flush_s}); end
        total++; if (sbq.size() == 0 || obs !== sbq[0]) begin bad++; $display("FAIL blt_hold_value got=%h", obs); end
        cycle(0, 0, 1, idle_r);
        total++; if ({cons, flush_s, ir_s} !== 3'b110) begin bad++; $display("FAIL blt_flush got=%b want=110", {cons, flush_s, ir_s}); end
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            total++; if (obs !== e) begin bad++; $display("FAIL blt_result got=%h want=%h", obs, e); end
        end
        total++; if ({obs.taken, obs.target, obs.mis} !== {1'b1, 32'h120, 1'b1}) begin bad++; $display("FAIL blt_fields got=%b/%h/%b want=1/120/1", obs.taken, obs.target, obs.mis); end
        cycle(0, 1, 1, mk(2'b01, 3'b000, 32'h0, 32'h0, 32'h300, 32'h8, 1'b1, 32'h308));
        total++; if ({ov_s, ir_s, acc, flush_s} !== 4'b0000) begin bad++; $display("FAIL blt_squash got=%b want=0000", {ov_s, ir_s, acc, flush_s}); end
        cycle(0, 0, 1, idle_r);
        total++; if ({ir_s, flush_s} !== 2'b10) begin bad++; $display("FAIL blt_after_squash got=%b want=10", {ir_s, flush_s}); end
    endtask

    task automatic test_bltu();
        cycle(0, 1, 0, mk(2'b01, 3'b110, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b0, 32'h0));
        cycle(0, 0, 1, idle_r);
        total++; if ({cons, flush_s} !== 2'b10) begin bad++; $display("FAIL bltu_consume got=%b want=10", {cons, flush_s}); end
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            total++; if (obs !== e) begin bad++; $display("FAIL bltu_result got=%h want=%h", obs, e); end
        end
        total++; if ({obs.taken, obs.redirect, obs.mis} !== {1'b0, 32'h104, 1'b0}) begin bad++; $display("FAIL bltu_fields got=%b/%h/%b want=0/104/0", obs.taken, obs.redirect, obs.mis); end
    endtask

    task automatic test_jumps();
        cycle(0, 1, 0, mk(2'b11, 3'b000, 32'h1003, 32'h0, 32'h200, 32'h4, 1'b1, 32'h1006));
        cycle(0, 0, 1, idle_r);
        total++; if ({cons, flush_s} !== 2'b10) begin bad++; $display("FAIL jalr_consume got=%b want=10", {cons, flush_s}); end
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            total++; if (obs !== e) begin bad++; $display("FAIL jalr_result got=%h want=%h", obs, e); end
        end
        total++; if ({obs.target, obs.misal, obs.mis, obs.link} !== {32'h1006, 1'b1, 1'b0, 32'h204}) begin bad++; $display("FAIL jalr_fields got=%h/%b/%b/%h want=1006/1/0/204", obs.target, obs.misal, obs.mis, obs.link); end
        cycle(0, 1, 0, mk(2'b10, 3'b000, 32'h0, 32'h0, 32'h40, 32'hFFFF_FFF8, 1'b1, 32'h3C));
        cycle(0, 0, 1, idle_r);
        total++; if ({cons, flush_s} !== 2'b11) begin bad++; $display("FAIL jal_flush got=%b want=11", {cons, flush_s}); end
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            total++; if (obs !== e) begin bad++; $display("FAIL jal_result got=%h want=%h", obs, e); end
        end
        cycle(0, 0, 0, idle_r);
        cycle(0, 1, 0, mk(2'b00, 3'b000, 32'h0, 32'h0, 32'h80, 32'h10, 1'b1, 32'h90));
        total++; if (acc !== 1'b1) begin bad++; $display("FAIL none_accept got=%b want=1", acc); end
        cycle(0, 0, 1, idle_r);
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            total++; if (obs !== e) begin bad++; $display("FAIL none_result got=%h want=%h", obs, e); end
        end
        total++; if ({obs.taken, obs.mis, flush_s} !== 3'b000) begin bad++; $display("FAIL none_fields got=%b want=000", {obs.taken, obs.mis, flush_s}); end
    endtask

    task automatic test_illegal();
        cycle(0, 1, 0, mk(2'b01, 3'b010, 32'h5, 32'h5, 32'hFFFF_FFFC, 32'h8, 1'b0, 32'h0));
        cycle(0, 0, 1, idle_r);
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            total++; if (obs !== e) begin bad++; $display("FAIL illegal_result got=%h want=%h", obs, e); end
        end
        total++; if ({obs.ill, obs.taken, obs.redirect} !== {1'b1, 1'b0, 32'h0}) begin bad++; $display("FAIL illegal_fields got=%b/%b/%h want=1/0/0", obs.ill, obs.taken, obs.redirect); end
    endtask

    task automatic test_back_to_back();
        req_t b[5];
        for (int i = 0; i < 5; i++) begin
            b[i] = mk(2'b01, 3'b000, 32'(i), 32'(i + (i % 2)), 32'h1000 + 32'(16 * i), 32'h40,
                      (i % 2) == 0, 32'h1040 + 32'(16 * i));
        end
        cycle(0, 1, 0, b[0]);
        for (int k = 0; k < 3; k++) begin
            cycle(0, 1, 0, b[1]);
            total++; if ({ov_s, ir_s, acc} !== 3'b100) begin bad++; $display("FAIL b2b_stall_ctl got=%b want=100", {ov_s, ir_s, acc}); end
            total++; if (sbq.size() == 0 || obs !== sbq[0]) begin bad++; $display("FAIL b2b_stall_value got=%h", obs); end
        end
        for (int i = 1; i < 5; i++) begin
            cycle(0, 1, 1, b[i]);
            total++; if ({acc, cons, flush_s} !== 3'b110) begin bad++; $display("FAIL b2b_stream got=%b want=110", {acc, cons, flush_s}); end
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                total++; if (obs !== e) begin bad++; $display("FAIL b2b_result got=%h want=%h", obs, e); end
            end
        end
        cycle(0, 0, 1, idle_r);
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            total++; if (obs !== e) begin bad++; $display("FAIL b2b_last got=%h want=%h", obs, e); end
        end
    endtask

    task automatic test_random();
        int n = 0;
        req_t r;
        logic [31:0] pool [4];
        logic [31:0] rv;
        pool[0] = 32'h0; pool[1] = 32'h1; pool[2] = 32'hFFFF_FFFF; pool[3] = 32'h8000_0000;
        for (int c = 0; c < 400 && (n < 40 || sbq.size() != 0); c++) begin
            r.op  = 2'($urandom_range(0, 3));
            r.f3  = 3'($urandom_range(0, 7));
            r.rs1 = pool[$urandom_range(0, 3)];
            r.rs2 = pool[$urandom_range(0, 3)];
            rv    = $urandom();
            r.pc  = {rv[31:2], 2'b00};
            r.imm = 32'($urandom_range(0, 255)) - 32'd128;
            r.pt  = 1'($urandom_range(0, 1));
            r.ptgt = ($urandom_range(0, 1) == 1) ?
                     ((r.op == 2'b11) ? ((r.rs1 + r.imm) & 32'hFFFF_FFFE) : (r.pc + r.imm)) : $urandom();
            cycle(0, n < 40, $urandom_range(0, 3) != 0, r);
            if (acc) n++;
            if (cons) begin
                if (sbq.size() == 0) begin
                    total++; bad++; $display("FAIL rand_underflow got=empty want=entry");
                end else begin
                    e = sbq.pop_front();
                    total++; if (obs !== e) begin bad++; $display("FAIL rand_result got=%h want=%h", obs, e); end
                    total++; if (flush_s !== e.mis) begin bad++; $display("FAIL rand_flush got=%b want=%b", flush_s, e.mis); end
                end
            end else begin
                total++; if (flush_s !== 1'b0) begin bad++; $display("FAIL rand_flush_idle got=%b want=0", flush_s); end
            end
        end
        total++; if (sbq.size() != 0 || n < 40) begin bad++; $display("FAIL rand_timeout got=%0d pending want=0", sbq.size()); end
        sbq.delete();
        cycle(0, 0, 0, idle_r);
        cycle(0, 0, 0, idle_r);
    endtask

    task automatic test_reset_full();
        cycle(0, 1, 0, mk(2'b01, 3'b100, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b0, 32'h0));
        total++; if (acc !== 1'b1) begin bad++; $display("FAIL rstfull_accept got=%b want=1", acc); end
        cycle(1, 0, 1, idle_r);
        total++; if ({ov_s, flush_s, ir_s} !== 3'b100) begin bad++; $display("FAIL rstfull_during got=%b want=100", {ov_s, flush_s, ir_s}); end
        sbq.delete();
        cycle(0, 0, 1, idle_r);
        total++; if ({ov_s, flush_s, ir_s} !== 3'b001) begin bad++; $display("FAIL rstfull_after got=%b want=001", {ov_s, flush_s, ir_s}); end
        cycle(0, 0, 1, idle_r);
        total++; if (flush_s !== 1'b0) begin bad++; $display("FAIL rstfull_no_flush got=%b want=0", flush_s); end
    endtask

    initial begin
        test_reset();
        test_blt_mispredict();
        test_bltu();
        test_jumps();
        test_illegal();
        test_back_to_back();
        test_random();
        test_reset_full();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 Parameter XLEN, default 32: operand, PC and target width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  upstream offers a resolve request.
REQ-005 in_ready  output  1  unit accepts the request this cycle.
REQ-006 op_kind  input  2  00 none, 01 cond branch, 10 JAL, 11 JALR.
REQ-007 br_funct3  input  3  branch condition (RV32I funct3 encoding).
REQ-008 rs_1, rs_2  input  XLEN  source operands.
REQ-009 pc, imm  input  XLEN  instruction PC, sign-extended immediate.
REQ-010 pred_taken  input  1; pred_target  input  XLEN: front-end prediction.
REQ-011 out_valid  output  1  registered result present.
REQ-012 out_ready  input  1  downstream consumes result.
REQ-013 taken  output  1; target  output  XLEN; link_addr  output  XLEN (pc+4).
REQ-014 mispredict  output  1; redirect_pc  output  XLEN; flush  output  1 (single-cycle pulse).
REQ-015 illegal  output  1 (reserved funct3); misalign  output  1 (taken, target[1]=1).

Function
REQ-016 Conditions: 000 EQ, 001 NE, 100 signed LT, 101 signed GE, 110 unsigned LT, 111 unsigned GE; 010/011 -> taken=0, illegal=1.
REQ-017 op_kind 10/11 -> taken=1; op_kind 00 -> taken=0, mispredict=0 regardless of prediction.
REQ-018 target = pc+imm for 01/10; (rs_1+imm) with bit0 cleared for 11; all adds modulo 2^XLEN, carry discarded.
REQ-019 mispredict = (taken != pred_taken) or (taken and target != pred_target).
REQ-020 redirect_pc = target when taken, else pc+4 (wraps 0xFFFFFFFC -> 0x00000000).
REQ-021 Latency: request accepted in cycle N -> all outputs valid from cycle N+1 and held stable while out_valid=1 and out_ready=0.
REQ-022 FSM states EMPTY, FULL, SQUASH; reset state EMPTY.
REQ-023 EMPTY: in_ready=1; in_valid -> FULL.
REQ-024 FULL, out_ready=0: hold, in_ready=0.
REQ-025 FULL, out_ready=1, held mispredict=0: in_ready=1; in_valid -> FULL (back-to-back reload), else EMPTY.
REQ-026 FULL, out_ready=1, held mispredict=1: flush=1 that cycle, in_ready=0, -> SQUASH.
REQ-027 SQUASH: out_valid=0, in_ready=0, in_valid ignored for exactly one cycle, -> EMPTY.
REQ-028 flush asserts only on the consumption handshake of a mispredicted result, never twice for one request.
REQ-029 misalign and illegal are informational; they do not alter the handshake or FSM.

Reset
REQ-030 rst in any state -> next state EMPTY, discarding any held result without flush.
REQ-031 Reset values: out_valid=0, flush=0, taken=0, mispredict=0, illegal=0, misalign=0, target/redirect_pc/link_addr=0.
REQ-032 in_ready=0 during the reset cycle, 1 in the first cycle after.

Structure
REQ-033 Shared package holds op_kind and funct3 encodings, FSM state typedef, XLEN default.
REQ-034 One combinational sub-module, branch_cond_eval (funct3, rs_1, rs_2 -> taken, illegal); remainder in the top.

Verification
REQ-035 BLT rs_1=0xFFFFFFFF, rs_2=1, pc=0x100, imm=0x20, pred_taken=0 -> taken=1, target=0x120, mispredict=1, flush one cycle on handshake, SQUASH blocks the next in_valid.
REQ-036 BLTU same operands, pred_taken=0 -> taken=0, redirect_pc=0x104, mispredict=0, no flush.
REQ-037 JALR rs_1=0x1003, imm=0x4, pred_taken=1, pred_target=0x1006 -> target=0x1006, misalign=1, mispredict=0, link_addr=pc+4.
REQ-038 Back-to-back correctly predicted BEQ stream, out_ready held 0 for 3 cycles -> outputs stable, in_ready=0, then one result per cycle.
REQ-039 funct3=010, pc=0xFFFFFFFC -> illegal=1, taken=0, redirect_pc=0x00000000.
REQ-040 rst asserted while FULL with mispredicted result -> next cycle out_valid=0, flush never asserted.
